// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: op codes, FSM states and op-decoding helpers for the HI/LO multiply/divide unit
package mips_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {MD_S_IDLE, MD_S_MUL, MD_S_DIV, MD_S_FIX} md_state_t;

    function automatic logic md_is_signed(input logic [2:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

    function automatic logic md_is_mul(input logic [2:0] op);
        return op == MD_MULT || op == MD_MULTU;
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/mips_div_step.sv
// mips_div_step: one combinational restoring-division step on a {rem,quo} pair
//   rem_in, quo_in  : partial remainder and dividend/quotient shift register
//   divisor         : unsigned divisor
//   rem_out, quo_out: pair after shifting in one dividend bit and retiring one quotient bit
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    assign trial   = {rem_in, quo_in[WIDTH-1]};
    assign diff    = trial - {1'b0, divisor};
    // trial < 2*divisor, so a clear top bit of the difference means trial >= divisor
    assign fits    = !diff[WIDTH];
    assign rem_out = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op, a, b     : op request (sampled when not busy), op code, rs and rt operands
//   abort               : cancel the in-flight op
//   busy, done          : op in progress, one-cycle completion pulse
//   div_by_zero         : valid with done for DIV/DIVU with b == 0
//   hi, lo              : architectural HI/LO registers
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    md_state_t                 state;
    logic [2*WIDTH-1:0]        acc;
    logic [2*WIDTH-1:0]        mul_next;
    logic [2*WIDTH-1:0]        nxt_acc;
    logic [2*WIDTH-1:0]        prod;
    logic [WIDTH+MUL_STEP-1:0] upper;
    logic [WIDTH-1:0]          opd;
    logic [WIDTH-1:0]          a_mag;
    logic [WIDTH-1:0]          b_mag;
    logic [WIDTH-1:0]          rem_o;
    logic [WIDTH-1:0]          quo_o;
    logic [WIDTH-1:0]          q_raw;
    logic [WIDTH-1:0]          r_raw;
    logic [CW-1:0]             cnt;
    logic                      sgn;
    logic                      neg_q;
    logic                      neg_r;
    logic                      last;
    logic                      idle;

    assign sgn   = md_is_signed(op);
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    assign idle  = state == MD_S_IDLE || state == MD_S_FIX;

    // acc = {partial product, remaining multiplier bits}; retire MUL_STEP multiplier bits per cycle
    assign upper    = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]}
                    + {{MUL_STEP{1'b0}}, opd} * {{WIDTH{1'b0}}, acc[MUL_STEP-1:0]};
    assign mul_next = {upper, acc[WIDTH-1:MUL_STEP]};

    mips_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .quo_in  (acc[WIDTH-1:0]),
        .divisor (opd),
        .rem_out (rem_o),
        .quo_out (quo_o)
    );

    assign nxt_acc = state == MD_S_MUL ? mul_next : {rem_o, quo_o};
    assign prod    = neg_q ? -nxt_acc : nxt_acc;
    assign q_raw   = nxt_acc[WIDTH-1:0];
    assign r_raw   = nxt_acc[2*WIDTH-1:WIDTH];
    assign last    = cnt == (state == MD_S_MUL ? MUL_LAST : DIV_LAST);

    // Sign correction is folded into the last iteration edge so hi/lo are already
    // valid in the FIX cycle, where done is high and a new op may be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_S_IDLE;
            acc         <= '0;
            opd         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (abort) begin
                state <= MD_S_IDLE;
                busy  <= 1'b0;
            end else if (idle) begin
                state <= MD_S_IDLE;
                cnt   <= '0;
                if (start && md_is_mul(op)) begin
                    state <= MD_S_MUL;
                    busy  <= 1'b1;
                    opd   <= a_mag;
                    acc   <= {{WIDTH{1'b0}}, b_mag};
                    neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r <= 1'b0;
                end else if (start && md_is_div(op) && b == '0) begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                end else if (start && md_is_div(op)) begin
                    state <= MD_S_DIV;
                    busy  <= 1'b1;
                    opd   <= b_mag;
                    acc   <= {{WIDTH{1'b0}}, a_mag};
                    neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r <= sgn && a[WIDTH-1];
                end else if (start && op == MD_MTHI) begin
                    hi   <= a;
                    done <= 1'b1;
                end else if (start && op == MD_MTLO) begin
                    lo   <= a;
                    done <= 1'b1;
                end
            end else begin
                acc <= nxt_acc;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state <= MD_S_FIX;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    hi    <= state == MD_S_MUL ? prod[2*WIDTH-1:WIDTH] : (neg_r ? -r_raw : r_raw);
                    lo    <= state == MD_S_MUL ? prod[WIDTH-1:0] : (neg_q ? -q_raw : q_raw);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed vectors for the multiply/divide unit (MUL_STEP 1 and 4)
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        busy, done, dbz, busy4, done4, dbz4;
    logic [31:0] hi, lo, hi4, lo4;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op on the MUL_STEP=1 unit and check latency, busy profile and results.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input bit chain, input bit intrude);
        int lat = -1;
        bit busy_ok = 1'b1;
        if (!chain) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (intrude && k == 5) begin
                start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd3;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        chk({tag, ".dbz"}, 64'(dbz), 64'(edbz));
    endtask

    task automatic run4(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo);
        int lat = -1;
        @(negedge clk);
        start4 = 1'b1; op = o; a = x; b = y;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".lat"}, 64'(lat), 64'd9);
        chk({tag, ".hi"}, 64'(hi4), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo4), 64'(elo));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dbz", 64'(dbz), 64'd0);
        rst_n = 1'b1;

        run("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
        @(negedge clk);
        chk("multu_max.done_pulse", 64'(done), 64'd0);
        run("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0);
        run("mult_min", MD_MULT, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0, 0, 0);
        run4("m4_mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run4("m4_multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        run("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
        run("divu", MD_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3, 1'b0, 0, 0);
        run("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 1'b0, 0, 0);
        run("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 1'b0, 0, 0);

        run("mthi11", MD_MTHI, 32'h11, 32'd0, 1, 32'h11, 32'h40000000 >> 30 == 1 ? 32'hFFFFFFFD : 32'hFFFFFFFD, 1'b0, 0, 0);
        run("mtlo22", MD_MTLO, 32'h22, 32'd0, 1, 32'h11, 32'h22, 1'b0, 0, 0);
        run("div0", MD_DIV, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1'b1, 0, 0);
        @(negedge clk);
        chk("div0.done_pulse", 64'(done), 64'd0);
        chk("div0.dbz_pulse", 64'(dbz), 64'd0);

        start = 1'b1; op = MD_MTHI; a = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b.mthi_done", 64'(done), 64'd1);
        chk("b2b.mthi_hi", 64'(hi), 64'hCAFEF00D);
        op = MD_MTLO; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.mtlo_done", 64'(done), 64'd1);
        chk("b2b.mtlo_lo", 64'(lo), 64'h1234);
        chk("b2b.busy", 64'(busy), 64'd0);

        run("intrude", MD_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0, 0, 1);
        run("chain", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1, 0);

        run("mthi_a", MD_MTHI, 32'hAAAA, 32'd0, 1, 32'hAAAA, 32'd14, 1'b0, 0, 0);
        run("mtlo_b", MD_MTLO, 32'hBBBB, 32'd0, 1, 32'hAAAA, 32'hBBBB, 1'b0, 0, 0);
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
        begin
            int seen = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) seen++;
                if (k == 10) abort = 1'b1;
            end
            @(negedge clk);
            abort = 1'b0;
            chk("abort.no_done", 64'(seen + int'(done)), 64'd0);
            chk("abort.busy", 64'(busy), 64'd0);
            chk("abort.hi", 64'(hi), 64'hAAAA);
            chk("abort.lo", 64'(lo), 64'hBBBB);
        end
        run("post_abort", MD_DIVU, 32'd9, 32'd2, 33, 32'd1, 32'd4, 1'b0, 1, 0);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = MD_MTHI; a = 32'hDEAD;
        @(negedge clk);
        chk("abort_start.done", 64'(done), 64'd0);
        chk("abort_start.hi", 64'(hi), 64'd1);
        op = MD_MULT; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", 64'(busy), 64'd0);

        @(negedge clk);
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", MD_DIVU, 32'd10, 32'd3, 33, 32'd1, 32'd3, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
